// File: rtl/dance_pad_conditioner_if.sv
// rtl/dance_pad_conditioner_if.sv - lane input/output bundle for dance_pad_conditioner
// master drives raw contacts and enable; slave returns conditioned pulses and levels.
interface dance_pad_conditioner_if #(
   parameter int NUM_PADS = 4
);
   logic [NUM_PADS-1:0] key_n;
   logic [NUM_PADS-1:0] pad_n;
   logic                enable;
   logic [NUM_PADS-1:0] press_pulse;
   logic [NUM_PADS-1:0] release_pulse;
   logic [NUM_PADS-1:0] press_level;
   logic                press_any;
   logic [NUM_PADS-1:0] stuck;

   modport master (
      output key_n, pad_n, enable,
      input  press_pulse, release_pulse, press_level, press_any, stuck
   );

   modport slave (
      input  key_n, pad_n, enable,
      output press_pulse, release_pulse, press_level, press_any, stuck
   );
endinterface

// File: rtl/dance_pad_conditioner.sv
// rtl/dance_pad_conditioner.sv - sync, merge and debounce button/pad lanes into press/release pulses
// Optional stuck-lane detection is built when PAD_STUCK_DETECT_EN is defined.
module dance_pad_conditioner #(
   parameter int NUM_PADS        = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int STUCK_CYCLES    = 250000000
) (
   input logic                     CLOCK_50,
   input logic                     resetn,
   dance_pad_conditioner_if.slave  pads
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      HELD        = 2'd2,
      DEB_RELEASE = 2'd3
   } lane_state_e;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_PADS-1:0] key_meta_q, key_meta_d, key_sync_q, key_sync_d;
   logic [NUM_PADS-1:0] pad_meta_q, pad_meta_d, pad_sync_q, pad_sync_d;
   logic [NUM_PADS-1:0] act;

   lane_state_e         state_q [NUM_PADS];
   lane_state_e         state_d [NUM_PADS];
   logic [CNT_W-1:0]    cnt_q   [NUM_PADS];
   logic [CNT_W-1:0]    cnt_d   [NUM_PADS];

   logic [NUM_PADS-1:0] press_evt, release_evt;
   logic [NUM_PADS-1:0] press_pulse_q, press_pulse_d;
   logic [NUM_PADS-1:0] release_pulse_q, release_pulse_d;
   logic [NUM_PADS-1:0] press_level_q, press_level_d;
   logic [NUM_PADS-1:0] stuck_q, stuck_d;
   logic                press_any_q, press_any_d;

   always_comb begin
      key_meta_d = pads.key_n;
      key_sync_d = key_meta_q;
      pad_meta_d = pads.pad_n;
      pad_sync_d = pad_meta_q;
   end

   // A lane is active if either its button or its pad contact is held.
   assign act = ~key_sync_q | ~pad_sync_q;

   always_comb begin
      for (int i = 0; i < NUM_PADS; i++) begin
         state_d[i]     = state_q[i];
         cnt_d[i]       = cnt_q[i];
         press_evt[i]   = 1'b0;
         release_evt[i] = 1'b0;
         case (state_q[i])
            IDLE: begin
               if (act[i]) begin
                  state_d[i] = DEB_PRESS;
                  cnt_d[i]   = '0;
               end
            end
            DEB_PRESS: begin
               if (!act[i]) begin
                  state_d[i] = IDLE;
               end else if (cnt_q[i] == DEB_LAST) begin
                  state_d[i]   = HELD;
                  press_evt[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            HELD: begin
               if (!act[i]) begin
                  state_d[i] = DEB_RELEASE;
                  cnt_d[i]   = '0;
               end
            end
            DEB_RELEASE: begin
               if (act[i]) begin
                  state_d[i] = HELD;
               end else if (cnt_q[i] == DEB_LAST) begin
                  state_d[i]     = IDLE;
                  release_evt[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            default: begin
               state_d[i] = IDLE;
               cnt_d[i]   = '0;
            end
         endcase
         press_level_d[i] = (state_d[i] == HELD) || (state_d[i] == DEB_RELEASE);
      end
   end

`ifdef PAD_STUCK_DETECT_EN
   localparam logic [27:0] STUCK_LAST = 28'(STUCK_CYCLES - 1);

   logic [27:0]         held_cnt_q [NUM_PADS];
   logic [27:0]         held_cnt_d [NUM_PADS];
   logic [NUM_PADS-1:0] in_hold;

   // Held counter saturates at the threshold so it can never wrap back to zero.
   always_comb begin
      for (int i = 0; i < NUM_PADS; i++) begin
         in_hold[i] = (state_q[i] == HELD) || (state_q[i] == DEB_RELEASE);
         if (!in_hold[i]) begin
            held_cnt_d[i] = '0;
         end else if (held_cnt_q[i] == STUCK_LAST) begin
            held_cnt_d[i] = held_cnt_q[i];
         end else begin
            held_cnt_d[i] = held_cnt_q[i] + 28'd1;
         end
         if (state_d[i] == IDLE) begin
            stuck_d[i] = 1'b0;
         end else begin
            stuck_d[i] = stuck_q[i] | (in_hold[i] && (held_cnt_q[i] == STUCK_LAST));
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            held_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PADS; i++) begin
            held_cnt_q[i] <= held_cnt_d[i];
         end
      end
   end
`else
   assign stuck_d = '0;
`endif

   // Pulses from a stuck lane are dropped; stuck_q is used so the IDLE-entry clear
   // does not let the final release pulse slip through.
   always_comb begin
      press_pulse_d   = press_evt & {NUM_PADS{pads.enable}} & ~stuck_q;
      release_pulse_d = release_evt & {NUM_PADS{pads.enable}} & ~stuck_q;
      press_any_d     = |press_pulse_d;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         key_meta_q      <= '1;
         key_sync_q      <= '1;
         pad_meta_q      <= '1;
         pad_sync_q      <= '1;
         for (int i = 0; i < NUM_PADS; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         press_pulse_q   <= '0;
         release_pulse_q <= '0;
         press_level_q   <= '0;
         press_any_q     <= 1'b0;
         stuck_q         <= '0;
      end else begin
         key_meta_q      <= key_meta_d;
         key_sync_q      <= key_sync_d;
         pad_meta_q      <= pad_meta_d;
         pad_sync_q      <= pad_sync_d;
         for (int i = 0; i < NUM_PADS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         press_level_q   <= press_level_d;
         press_any_q     <= press_any_d;
         stuck_q         <= stuck_d;
      end
   end

   assign pads.press_pulse   = press_pulse_q;
   assign pads.release_pulse = release_pulse_q;
   assign pads.press_level   = press_level_q;
   assign pads.press_any     = press_any_q;
   assign pads.stuck         = stuck_q;

endmodule
